// File: rtl/proc_feeder.sv
// Instruction sequencer feeding the 8-bit proc datapath: program RAM, issue/immediate/wait/gap
// sequencing, Done watchdog and program-end pulse. Define PROC_FEEDER_LOOP_EN to repeat the program forever.
module proc_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TMO   = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [7:0]    i_ld_data,
    input  logic [AW:0]   i_prog_len,
    input  logic          i_start,
    input  logic          i_done,
    output logic [7:0]    o_din,
    output logic          o_run,
    output logic [AW:0]   o_pc,
    output logic          o_busy,
    output logic          o_prog_end,
    output logic          o_err
);

    // state  | meaning
    // IDLE   | waiting for Start, RAM loadable
    // ISSUE  | instruction word on DIN, Run high
    // IMM    | immediate word of an mvi on DIN
    // WAIT   | Run high, waiting for Done with watchdog
    // GAP    | Run low for one cycle, PC advances
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_GAP} state_t;

    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] WCNT_LAST = CW'(TMO - 1);
    localparam logic [AW:0]   PC_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   PC_TWO    = (AW+1)'(2);

    logic [7:0]    r_mem [DEPTH];
    state_t        r_state;
    logic [AW:0]   r_pc;
    logic [AW:0]   r_len;
    logic [7:0]    r_din;
    logic          r_run;
    logic          r_busy;
    logic          r_prog_end;
    logic          r_err;
    logic          r_mvi;
    logic [CW-1:0] r_wcnt;

    logic [AW:0]   w_pc_nxt;
    logic [AW-1:0] w_imm_addr;
    logic          w_last;

    assign w_pc_nxt   = r_pc + (r_mvi ? PC_TWO : PC_ONE);
    assign w_imm_addr = r_pc[AW-1:0] + {{(AW-1){1'b0}}, 1'b1};
    assign w_last     = (w_pc_nxt >= r_len);

    // RAM has no reset; writes only while idle
    always_ff @(posedge i_clk) begin
        if (i_ld_en && r_state == S_IDLE) begin
            r_mem[i_ld_addr] <= i_ld_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_len      <= '0;
            r_din      <= '0;
            r_run      <= 1'b0;
            r_busy     <= 1'b0;
            r_prog_end <= 1'b0;
            r_err      <= 1'b0;
            r_mvi      <= 1'b0;
            r_wcnt     <= '0;
        end else begin
            r_prog_end <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len <= i_prog_len;
                        r_pc  <= '0;
                        r_err <= 1'b0;
                        if (i_prog_len == '0) begin
                            r_prog_end <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_din   <= r_mem[0];
                            r_run   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wcnt <= '0;
                    if (r_din[7:6] == 2'b01) begin
                        r_mvi   <= 1'b1;
                        r_state <= S_IMM;
                        r_din   <= r_mem[w_imm_addr];
                    end else begin
                        r_mvi   <= 1'b0;
                        r_state <= S_WAIT;
                        r_din   <= '0;
                    end
                end
                S_IMM: begin
                    r_din <= '0;
                    if (i_done) begin
                        r_state <= S_GAP;
                        r_run   <= 1'b0;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Done on the terminal cycle still wins over the timeout
                    if (i_done) begin
                        r_state <= S_GAP;
                        r_run   <= 1'b0;
                    end else if (r_wcnt == WCNT_LAST) begin
                        r_state <= S_IDLE;
                        r_run   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_last) begin
                        r_prog_end <= 1'b1;
`ifdef PROC_FEEDER_LOOP_EN
                        r_pc    <= '0;
                        r_state <= S_ISSUE;
                        r_din   <= r_mem[0];
                        r_run   <= 1'b1;
`else
                        r_pc    <= w_pc_nxt;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_pc    <= w_pc_nxt;
                        r_state <= S_ISSUE;
                        r_din   <= r_mem[w_pc_nxt[AW-1:0]];
                        r_run   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_run   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_din   <= '0;
                end
            endcase
        end
    end

    assign o_din      = r_din;
    assign o_run      = r_run;
    assign o_pc       = r_pc;
    assign o_busy     = r_busy;
    assign o_prog_end = r_prog_end;
    assign o_err      = r_err;

endmodule

// File: tb/tb_proc_feeder.sv
// Directed bench for proc_feeder with a small behavioural proc model answering Done.
module tb_proc_feeder;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          tb_done = 1'b0;
    logic          pm_done = 1'b0;
    logic          pm_en = 1'b0;
    logic          done;
    logic [7:0]    din;
    logic          run;
    logic [AW:0]   pc;
    logic          busy;
    logic          prog_end;
    logic          err;

    int total = 0;
    int bad = 0;

    assign done = pm_en ? pm_done : tb_done;

    always #5 clk = ~clk;

    proc_feeder #(.DEPTH(16), .AW(AW), .TMO(7)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ld_en(ld_en), .i_ld_addr(ld_addr),
        .i_ld_data(ld_data), .i_prog_len(prog_len), .i_start(start), .i_done(done),
        .o_din(din), .o_run(run), .o_pc(pc), .o_busy(busy),
        .o_prog_end(prog_end), .o_err(err)
    );

    // proc model: mvi finishes in the immediate cycle, others in the first wait cycle
    logic [7:0] R [8];
    logic [7:0] pm_ir;
    int         pm_ph = 0;
    always @(negedge clk) begin
        if (!pm_en || !rst_n) begin
            pm_ph   = 0;
            pm_done = 1'b0;
        end else begin
            case (pm_ph)
                0: if (run) begin
                       pm_ir = din;
                       pm_ph = (din[7:6] == 2'b01) ? 1 : 2;
                   end
                1: begin
                       R[pm_ir[5:3]] = din;
                       pm_done = 1'b1;
                       pm_ph = 3;
                   end
                2: begin
                       if (pm_ir[7:6] == 2'b10) R[pm_ir[5:3]] = R[pm_ir[5:3]] + R[pm_ir[2:0]];
                       else if (pm_ir[7:6] == 2'b00) R[pm_ir[5:3]] = R[pm_ir[2:0]];
                       pm_done = 1'b1;
                       pm_ph = 3;
                   end
                default: begin
                       pm_done = 1'b0;
                       if (!run) pm_ph = 0;
                   end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic go(input int len);
        prog_len = (AW+1)'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // run until ProgEnd or Err, counting Run windows
    task automatic wait_end(input int budget, output int windows, output int seen);
        logic prev;
        prev = run;
        windows = (run) ? 1 : 0;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (prog_end || err) begin seen = 1; break; end
            @(negedge clk);
            if (run && !prev) windows++;
            prev = run;
        end
    endtask

    int win, seen, t0, t1, t2;

    initial begin
        for (int i = 0; i < 8; i++) R[i] = 8'h00;
        @(negedge clk);
        chk("rst_run", run, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc", pc, 0);
        chk("rst_din", din, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // mvi R0,5 with Done in the immediate cycle
        pm_en = 1'b1;
        load(0, 8'h40); load(1, 8'h05);
        go(2);
        chk("t1_issue_din", din, 8'h40); chk("t1_issue_run", run, 1); chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_imm_din", din, 8'h05); chk("t1_imm_run", run, 1);
        @(negedge clk);
        chk("t1_gap_run", run, 0); chk("t1_gap_din", din, 0); chk("t1_gap_pe", prog_end, 0);
        @(negedge clk);
        chk("t1_pe", prog_end, 1); chk("t1_pc", pc, 2); chk("t1_busy_end", busy, 0);
        chk("t1_r0", R[0], 8'h05);
        @(negedge clk);
        chk("t1_pe_once", prog_end, 0);

        // mvi R0,3; mvi R1,2; add R0,R1
        load(0, 8'h40); load(1, 8'h03); load(2, 8'h48); load(3, 8'h02); load(4, 8'h81);
        go(5);
        wait_end(100, win, seen);
        chk("t2_end_seen", seen, 1); chk("t2_pe", prog_end, 1);
        chk("t2_r0", R[0], 8'h05); chk("t2_r1", R[1], 8'h02);
        chk("t2_windows", win, 3); chk("t2_pc", pc, 5); chk("t2_err", err, 0);
        @(negedge clk);

        // empty program
        go(0);
        chk("t3_pe", prog_end, 1); chk("t3_run", run, 0); chk("t3_busy", busy, 0);
        @(negedge clk);
        chk("t3_pe_once", prog_end, 0); chk("t3_run2", run, 0);

        // watchdog: add with Done never arriving
        pm_en = 1'b0; tb_done = 1'b0;
        load(0, 8'h81);
        go(1);
        chk("t4_issue_din", din, 8'h81);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("t4_wait_run", run, 1); chk("t4_wait_err", err, 0);
        end
        @(negedge clk);
        chk("t4_err", err, 1); chk("t4_run", run, 0); chk("t4_pc", pc, 0); chk("t4_busy", busy, 0);
        @(negedge clk);
        chk("t4_err_sticky", err, 1);
        go(0);
        chk("t4_err_clr", err, 0);
        @(negedge clk);

        // Done on the last watchdog cycle wins
        go(1);
        for (int i = 0; i < 7; i++) @(negedge clk);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        chk("t4b_gap_run", run, 0); chk("t4b_err", err, 0);
        @(negedge clk);
        chk("t4b_pe", prog_end, 1); chk("t4b_pc", pc, 1); chk("t4b_err2", err, 0);

        // Start and LdEn while busy are ignored
        go(1);
        @(negedge clk);
        start = 1'b1; prog_len = 5'd3; ld_en = 1'b1; ld_addr = '0; ld_data = 8'hFF;
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        chk("t5_busy", busy, 1); chk("t5_pc", pc, 0);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        @(negedge clk);
        chk("t5_pe", prog_end, 1); chk("t5_pc_end", pc, 1);
        go(1);
        chk("t5_ram_kept", din, 8'h81);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_run", run, 0); chk("t5_rst_pc", pc, 0); chk("t5_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // mvi in the last word takes its immediate from address 0
        pm_en = 1'b1;
        load(0, 8'h07);
        for (int a = 1; a < 15; a++) load(a, 8'h00);
        load(15, 8'h50);
        go(16);
        wait_end(300, win, seen);
        chk("t6_end_seen", seen, 1); chk("t6_r2", R[2], 8'h07);
        chk("t6_pc", pc, 17); chk("t6_windows", win, 16);
        @(negedge clk);

`ifdef PROC_FEEDER_LOOP_EN
        load(0, 8'h01);
        go(1);
        t0 = -1; t1 = -1; t2 = -1;
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            if (prog_end) begin
                chk("loop_pc", pc, 0); chk("loop_run", run, 1); chk("loop_din", din, 8'h01);
                if (t0 < 0) t0 = i; else if (t1 < 0) t1 = i; else t2 = i;
            end
            @(negedge clk);
        end
        chk("loop_seen", (t2 >= 0), 1);
        chk("loop_period", t2 - t1, t1 - t0);
        chk("loop_period3", t1 - t0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`else
        t0 = 0; t1 = 0; t2 = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "timeout");
    end
endmodule
